// File: rtl/buzzer_ctrl_if.sv
// buzzer_ctrl_if: front-panel buzzer control bundle.
// Ports: key_ready, alarm_req, alarm_stop, mute (to ctrl); alarm_active, busy, bee (from ctrl).
interface buzzer_ctrl_if;
   logic key_ready;
   logic alarm_req;
   logic alarm_stop;
   logic mute;
   logic alarm_active;
   logic busy;
   logic bee;

   modport master (
      output key_ready, alarm_req, alarm_stop, mute,
      input  alarm_active, busy, bee
   );

   modport slave (
      input  key_ready, alarm_req, alarm_stop, mute,
      output alarm_active, busy, bee
   );
endinterface

// File: rtl/buzzer_ctrl.sv
// buzzer_ctrl: key-click tone and cadenced alarm tone on one buzzer pin.
// Ports: clk, rst_n (async, active low), bus (buzzer_ctrl_if.slave).
module buzzer_ctrl #(
   parameter int CLK_HZ       = 25000000,
   parameter int KEY_MS       = 100,
   parameter int ALARM_MS     = 10000,
   parameter int ALARM_ON_MS  = 500,
   parameter int ALARM_OFF_MS = 500,
   parameter int KEY_HALF     = 12500,
   parameter int ALARM_HALF   = 25000,
   parameter int ACTIVE_LOW   = 1
) (
   input logic          clk,
   input logic          rst_n,
   buzzer_ctrl_if.slave bus
);

   localparam int DIV    = CLK_HZ / 1000;
   localparam int PW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int KW     = $clog2(KEY_MS + 1);
   localparam int AW     = $clog2(ALARM_MS + 1);
   localparam int PH_MAX = (ALARM_ON_MS > ALARM_OFF_MS) ?
                           ALARM_ON_MS : ALARM_OFF_MS;
   localparam int PHW    = $clog2(PH_MAX + 1);
   localparam int H_MAX  = (KEY_HALF > ALARM_HALF) ? KEY_HALF : ALARM_HALF;
   localparam int HW     = (H_MAX > 1) ? $clog2(H_MAX) : 1;
   localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

   typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2} state_t;
   typedef enum logic [1:0] {SEL_NONE, SEL_KEY, SEL_ALM} sel_t;

   // shared ms prescaler
   logic [PW-1:0] pre_cnt;
   logic          tick;

   assign tick = (pre_cnt == PW'(DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     pre_cnt <= '0;
      else if (tick)  pre_cnt <= '0;
      else            pre_cnt <= pre_cnt + PW'(1);
   end

   // rising-edge detect
   logic key_prev;
   logic req_prev;
   logic key_edge;
   logic req_edge;

   assign key_edge = bus.key_ready & ~key_prev;
   assign req_edge = bus.alarm_req & ~req_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_prev <= 1'b0;
         req_prev <= 1'b0;
      end else begin
         key_prev <= bus.key_ready;
         req_prev <= bus.alarm_req;
      end
   end

   // key channel
   logic [KW-1:0] key_cnt;
   logic [KW-1:0] key_nxt;

   always_comb begin
      key_nxt = key_cnt;
      if (key_edge)                   key_nxt = KW'(KEY_MS);
      else if (tick && key_cnt != '0) key_nxt = key_cnt - KW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) key_cnt <= '0;
      else        key_cnt <= key_nxt;
   end

   // alarm FSM
   state_t         state;
   state_t         state_nxt;
   logic [AW-1:0]  alarm_cnt;
   logic [PHW-1:0] phase_cnt;
   logic           alarm_on;
   logic           active_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // end of alarm outranks the phase toggle; stop outranks everything
   always_comb begin
      state_nxt = state;
      if (bus.alarm_stop) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: if (req_edge) state_nxt = ON;
            ON: if (tick) begin
               if (alarm_cnt == AW'(1))       state_nxt = IDLE;
               else if (phase_cnt == PHW'(1)) state_nxt = OFF;
            end
            OFF: if (tick) begin
               if (alarm_cnt == AW'(1))       state_nxt = IDLE;
               else if (phase_cnt == PHW'(1)) state_nxt = ON;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      alarm_on   = (state == ON);
      active_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alarm_cnt <= '0;
         phase_cnt <= '0;
      end else if (state_nxt == IDLE) begin
         alarm_cnt <= '0;
         phase_cnt <= '0;
      end else if (state == IDLE) begin
         alarm_cnt <= AW'(ALARM_MS);
         phase_cnt <= PHW'(ALARM_ON_MS);
      end else if (tick) begin
         if (alarm_cnt != '0) alarm_cnt <= alarm_cnt - AW'(1);
         if (phase_cnt == PHW'(1))
            phase_cnt <= (state == ON) ? PHW'(ALARM_OFF_MS)
                                       : PHW'(ALARM_ON_MS);
         else if (phase_cnt != '0)
            phase_cnt <= phase_cnt - PHW'(1);
      end
   end

   // status flags track the state being entered, so they are not delayed
   logic alarm_active_q;
   logic busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alarm_active_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         alarm_active_q <= active_nxt;
         busy_q         <= active_nxt | (key_nxt != '0);
      end
   end

   // tone select: key click overrides the alarm
   sel_t          sel;
   sel_t          sel_prev;
   logic [HW-1:0] half_m1;

   always_comb begin
      sel     = SEL_NONE;
      half_m1 = HW'(ALARM_HALF - 1);
      if (key_cnt != '0) begin
         sel     = SEL_KEY;
         half_m1 = HW'(KEY_HALF - 1);
      end else if (alarm_on) begin
         sel     = SEL_ALM;
      end
   end

   // tone generator restarts from a clean phase on every selection change
   logic [HW-1:0] half_cnt;
   logic          tone;
   logic          bee_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_prev <= SEL_NONE;
         half_cnt <= '0;
         tone     <= 1'b0;
         bee_q    <= IDLE_LVL;
      end else begin
         sel_prev <= sel;
         if (sel == SEL_NONE || sel != sel_prev) begin
            half_cnt <= '0;
            tone     <= 1'b0;
         end else if (half_cnt == half_m1) begin
            half_cnt <= '0;
            tone     <= ~tone;
         end else begin
            half_cnt <= half_cnt + HW'(1);
         end
         if (sel == SEL_NONE || bus.mute) bee_q <= IDLE_LVL;
         else                             bee_q <= tone ^ IDLE_LVL;
      end
   end

   assign bus.alarm_active = alarm_active_q;
   assign bus.busy         = busy_q;
   assign bus.bee          = bee_q;

endmodule

// File: tb/tb_buzzer_ctrl.sv
// tb_buzzer_ctrl: random and directed stimulus against a tick/phase model.
// Ports: none (top-level bench).
module tb_buzzer_ctrl;

   localparam int TICK   = 10;
   localparam int KEY_MS = 5;
   localparam int AL_MS  = 20;
   localparam int ON_MS  = 4;
   localparam int OFF_MS = 3;
   localparam int KH     = 2;
   localparam int AH     = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   buzzer_ctrl_if bus();

   buzzer_ctrl #(
      .CLK_HZ(10000), .KEY_MS(KEY_MS), .ALARM_MS(AL_MS),
      .ALARM_ON_MS(ON_MS), .ALARM_OFF_MS(OFF_MS),
      .KEY_HALF(KH), .ALARM_HALF(AH), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // model: cycles since reset, ticks left on key, ticks elapsed in alarm
   int m_n, m_key, m_act, m_el, m_pk, m_pr;
   int m_selp, m_j, m_tone;
   int exp_bee, exp_busy, exp_act;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_n = 0; m_key = 0; m_act = 0; m_el = 0;
      m_pk = 0; m_pr = 0; m_selp = 0; m_j = 0; m_tone = 0;
      exp_bee = 1; exp_busy = 0; exp_act = 0;
   endtask

   task automatic model_edge();
      int sel;
      int h;
      bit tick;
      bit ke;
      bit re;
      sel = (m_key > 0) ? 1 :
            (m_act != 0 && (m_el % (ON_MS + OFF_MS)) < ON_MS) ? 2 : 0;
      if (sel == 0) begin
         exp_bee = 1;
         m_tone = 0;
         m_selp = 0;
      end else begin
         h = (sel == 1) ? KH : AH;
         exp_bee = bus.mute ? 1 : (m_tone ^ 1);
         if (sel != m_selp) m_j = 0;
         else m_j++;
         m_tone = (m_j / h) % 2;
         m_selp = sel;
      end
      tick = ((m_n % TICK) == TICK - 1);
      m_n++;
      ke = bus.key_ready && m_pk == 0;
      re = bus.alarm_req && m_pr == 0;
      if (ke) m_key = KEY_MS;
      else if (tick && m_key > 0) m_key--;
      if (bus.alarm_stop) begin
         m_act = 0;
      end else if (m_act == 0) begin
         if (re) begin
            m_act = 1;
            m_el = 0;
         end
      end else if (tick) begin
         m_el++;
         if (m_el == AL_MS) m_act = 0;
      end
      m_pk = bus.key_ready;
      m_pr = bus.alarm_req;
      exp_act = m_act;
      exp_busy = (m_act != 0 || m_key > 0) ? 1 : 0;
   endtask

   // called at a falling edge; returns at the next falling edge
   task automatic step(input logic k, input logic r,
                       input logic s, input logic m);
      bus.key_ready = k;
      bus.alarm_req = r;
      bus.alarm_stop = s;
      bus.mute = m;
      @(posedge clk);
      model_edge();
      #1;
      chk("bee", bus.bee, exp_bee);
      chk("busy", bus.busy, exp_busy);
      chk("alarm_active", bus.alarm_active, exp_act);
      @(negedge clk);
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_bee", bus.bee, 1);
      chk("arst_active", bus.alarm_active, 0);
      chk("arst_busy", bus.busy, 0);
      bus.key_ready = 0; bus.alarm_req = 0;
      bus.alarm_stop = 0; bus.mute = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int bc;
      logic r, m;
      bus.key_ready = 0; bus.alarm_req = 0;
      bus.alarm_stop = 0; bus.mute = 0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_bee", bus.bee, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_active", bus.alarm_active, 0);

      repeat (200) step(0, 0, 0, 0);

      bc = 0;
      step(1, 0, 0, 0);
      bc += int'(bus.busy);
      repeat (59) begin
         step(0, 0, 0, 0);
         bc += int'(bus.busy);
      end
      chk("key_len_ok", (bc >= 41 && bc <= 50), 1);

      step(1, 0, 0, 0);
      repeat (30) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      repeat (60) step(0, 0, 0, 0);

      repeat (260) step(0, 1, 0, 0);
      chk("no_restart", bus.alarm_active, 0);
      repeat (5) step(0, 0, 0, 0);

      repeat (16) step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      repeat (60) step(0, 1, 0, 0);
      repeat (20) step(0, 1, 0, 1);
      chk("mute_busy", bus.busy, 1);
      repeat (40) step(0, 1, 0, 0);

      step(0, 0, 0, 0);
      step(0, 1, 1, 0);
      chk("stop_wins", bus.alarm_active, 0);
      step(0, 0, 0, 0);
      repeat (55) step(0, 1, 0, 0);
      async_reset();
      repeat (30) step(0, 0, 0, 0);

      r = 0;
      m = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 119) == 0) r = ~r;
         if ($urandom_range(0, 79) == 0) m = ~m;
         step(($urandom_range(0, 59) == 0), r,
              ($urandom_range(0, 299) == 0), m);
         if (i == 2000) begin
            async_reset();
            r = 0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
